// File: rtl/memory_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with fixed wait states.
// Optional macro ARBITER_ROUND_ROBIN_EN: alternate priority under contention (default: data over fetch).
module memory_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16,
  parameter int WAIT_STATES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fetch_request,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  output logic                     fetch_ready,
  output logic [DATA_WIDTH-1:0]    fetch_data,
  input  logic                     data_request,
  input  logic                     data_write,
  input  logic [ADDRESS_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0]    data_write_data,
  output logic                     data_ready,
  output logic [DATA_WIDTH-1:0]    data_read_data,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0]    memory_write_data,
  output logic                     memory_write_enable,
  input  logic [DATA_WIDTH-1:0]    memory_read_data,
  output logic                     busy
);

  // state  | meaning
  // IDLE   | no access in flight; sample requests and grant one
  // ACCESS | latched address driven; wait counter running down
  // DONE   | one-cycle ready pulse to the granted side

  localparam int COUNT_WIDTH = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] wait_count;
  logic                   grant_is_data;
  logic                   access_write;
  logic                   data_first;
  logic                   grant_data_now;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_grant_data;
  assign data_first = !last_grant_data;
`else
  assign data_first = 1'b1;
`endif

  // A lone requester always wins; priority only matters when both are up.
  assign grant_data_now = data_request && (!fetch_request || data_first);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state               <= IDLE;
      wait_count          <= '0;
      grant_is_data       <= 1'b0;
      access_write        <= 1'b0;
      fetch_ready         <= 1'b0;
      fetch_data          <= '0;
      data_ready          <= 1'b0;
      data_read_data      <= '0;
      memory_address      <= '0;
      memory_write_data   <= '0;
      memory_write_enable <= 1'b0;
      busy                <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_grant_data     <= 1'b0;
`endif
    end else begin
      fetch_ready         <= 1'b0;
      data_ready          <= 1'b0;
      memory_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_request || data_request) begin
            state         <= ACCESS;
            busy          <= 1'b1;
            wait_count    <= COUNT_WIDTH'(WAIT_STATES);
            grant_is_data <= grant_data_now;
`ifdef ARBITER_ROUND_ROBIN_EN
            last_grant_data <= grant_data_now;
`endif
            if (grant_data_now) begin
              memory_address      <= data_address;
              memory_write_data   <= data_write_data;
              access_write        <= data_write;
              memory_write_enable <= data_write;
            end else begin
              memory_address <= fetch_address;
              access_write   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (wait_count == '0) begin
            state <= DONE;
            if (grant_is_data) begin
              data_ready <= 1'b1;
              if (!access_write) data_read_data <= memory_read_data;
            end else begin
              fetch_ready <= 1'b1;
              fetch_data  <= memory_read_data;
            end
          end else begin
            wait_count <= wait_count - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: one instance with WAIT_STATES=2, one with WAIT_STATES=0.
// Contention expectations follow ARBITER_ROUND_ROBIN_EN when the bench is built with it.
module tb_memory_port_arbiter;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // WAIT_STATES = 2 instance
  logic        reset;
  logic        fetch_request, data_request, data_write;
  logic [15:0] fetch_address, data_address;
  logic [31:0] data_write_data;
  logic        fetch_ready, data_ready, memory_write_enable, busy;
  logic [31:0] fetch_data, data_read_data, memory_write_data, memory_read_data;
  logic [15:0] memory_address;

  // WAIT_STATES = 0 instance
  logic        z_reset;
  logic        z_fetch_request, z_data_request, z_data_write;
  logic [15:0] z_fetch_address, z_data_address;
  logic [31:0] z_data_write_data;
  logic        z_fetch_ready, z_data_ready, z_memory_write_enable, z_busy;
  logic [31:0] z_fetch_data, z_data_read_data, z_memory_write_data, z_memory_read_data;
  logic [15:0] z_memory_address;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] mem_model(input logic [15:0] a);
    case (a)
      16'h0040: mem_model = 32'hDEADBEEF;
      16'h0002: mem_model = 32'h0000A0B1;
      default:  mem_model = {16'hC0DE, a};
    endcase
  endfunction

  assign memory_read_data   = mem_model(memory_address);
  assign z_memory_read_data = mem_model(z_memory_address);

  memory_port_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(16), .WAIT_STATES(2)) dut (
    .clock(clock), .reset(reset),
    .fetch_request(fetch_request), .fetch_address(fetch_address),
    .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .data_request(data_request), .data_write(data_write),
    .data_address(data_address), .data_write_data(data_write_data),
    .data_ready(data_ready), .data_read_data(data_read_data),
    .memory_address(memory_address), .memory_write_data(memory_write_data),
    .memory_write_enable(memory_write_enable), .memory_read_data(memory_read_data),
    .busy(busy)
  );

  memory_port_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(16), .WAIT_STATES(0)) dut_ws0 (
    .clock(clock), .reset(z_reset),
    .fetch_request(z_fetch_request), .fetch_address(z_fetch_address),
    .fetch_ready(z_fetch_ready), .fetch_data(z_fetch_data),
    .data_request(z_data_request), .data_write(z_data_write),
    .data_address(z_data_address), .data_write_data(z_data_write_data),
    .data_ready(z_data_ready), .data_read_data(z_data_read_data),
    .memory_address(z_memory_address), .memory_write_data(z_memory_write_data),
    .memory_write_enable(z_memory_write_enable), .memory_read_data(z_memory_read_data),
    .busy(z_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance into the next cycle and settle past the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    fetch_request = 1'b0;
    data_request  = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},   busy, 0);
    check({tag, " f_rdy"},  fetch_ready, 0);
    check({tag, " d_rdy"},  data_ready, 0);
    check({tag, " we"},     memory_write_enable, 0);
    check({tag, " addr"},   memory_address, 0);
    check({tag, " wdata"},  memory_write_data, 0);
    check({tag, " f_data"}, fetch_data, 0);
    check({tag, " d_data"}, data_read_data, 0);
  endtask

  task automatic single_load();
    data_request = 1'b1;
    data_write   = 1'b0;
    data_address = 16'h0040;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("load c%0d d_rdy", c), data_ready, (c == 4));
      check($sformatf("load c%0d busy", c), busy, (c <= 4));
      check($sformatf("load c%0d we", c), memory_write_enable, 0);
      if (c == 1) check("load addr", memory_address, 16'h0040);
      if (c == 4) begin
        check("load d_data", data_read_data, 32'hDEADBEEF);
        data_request = 1'b0;
      end
    end
  endtask

  task automatic run_pair(input bit data_first_exp, input string tag);
    fetch_request = 1'b1;
    fetch_address = 16'h0100;
    data_request  = 1'b1;
    data_write    = 1'b0;
    data_address  = 16'h0040;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("%s c%0d d_rdy", tag, c), data_ready,
            data_first_exp ? (c == 4) : (c == 9));
      check($sformatf("%s c%0d f_rdy", tag, c), fetch_ready,
            data_first_exp ? (c == 9) : (c == 4));
      if (data_ready) data_request = 1'b0;
      if (fetch_ready) fetch_request = 1'b0;
    end
    check({tag, " f_data"}, fetch_data, 32'hC0DE0100);
    check({tag, " d_data"}, data_read_data, 32'hDEADBEEF);
  endtask

  initial begin
    reset = 1'b1; fetch_request = 0; data_request = 0; data_write = 0;
    fetch_address = '0; data_address = '0; data_write_data = '0;
    z_reset = 1'b0; z_fetch_request = 0; z_data_request = 0; z_data_write = 0;
    z_fetch_address = '0; z_data_address = '0; z_data_write_data = '0;

    reset = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    z_reset = 1'b1;

    single_load();

    data_request    = 1'b1;
    data_write      = 1'b1;
    data_address    = 16'h0010;
    data_write_data = 32'h12345678;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("store c%0d we", c), memory_write_enable, (c == 1));
      check($sformatf("store c%0d d_rdy", c), data_ready, (c == 4));
      if (c == 1) begin
        check("store addr", memory_address, 16'h0010);
        check("store wdata", memory_write_data, 32'h12345678);
      end
      if (c == 4) begin
        check("store keeps d_data", data_read_data, 32'hDEADBEEF);
        data_request = 1'b0;
      end
    end

    do_reset();
    run_pair(1'b1, "pair1");
    run_pair(1'b1, "pair2");
    single_load();
`ifdef ARBITER_ROUND_ROBIN_EN
    run_pair(1'b0, "pair3");
`else
    run_pair(1'b1, "pair3");
`endif

    data_request    = 1'b1;
    data_write      = 1'b1;
    data_address    = 16'h0020;
    data_write_data = 32'hCAFEF00D;
    tick();
    check("rst store c1 we", memory_write_enable, 1);
    tick();
    check("rst store c2 busy", busy, 1);
    reset = 1'b0;
    tick();
    check_all_zero("rst mid");
    reset = 1'b1;
    data_request = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      tick();
      check($sformatf("rst post c%0d we", c), memory_write_enable, 0);
      check($sformatf("rst post c%0d d_rdy", c), data_ready, 0);
      check($sformatf("rst post c%0d busy", c), busy, 0);
    end

    z_fetch_request = 1'b1;
    z_fetch_address = 16'h0002;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("ws0 c%0d f_rdy", c), z_fetch_ready, (c == 2 || c == 5));
      check($sformatf("ws0 c%0d busy", c), z_busy, (c % 3 != 0));
      check($sformatf("ws0 c%0d we", c), z_memory_write_enable, 0);
      if (c == 1) check("ws0 addr", z_memory_address, 16'h0002);
      if (c == 2) check("ws0 f_data", z_fetch_data, 32'h0000A0B1);
    end
    z_fetch_request = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares the single-port main memory between instruction fetch and the load/store path driven by the control unit. Each side raises a request and holds it until it receives a one-cycle ready pulse. The block sequences each access through a fixed wait-state count and registers the read data. It sits between the fetch logic and datapath on one side and the memory macro on the other. It also exports a busy flag so the control unit can stall.

## Interface
- DATA_WIDTH, 32, width of memory words and data buses
- ADDRESS_WIDTH, 16, width of memory addresses
- WAIT_STATES, 2, extra cycles an access holds the address before read data is sampled (0 allowed)

- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- fetch_request  input  1  instruction fetch wants a read
- fetch_address  input  ADDRESS_WIDTH  fetch address, valid while fetch_request high
- fetch_ready  output  1  one-cycle pulse; fetch_data valid this cycle
- fetch_data  output  DATA_WIDTH  registered instruction word
- data_request  input  1  load/store wants an access
- data_write  input  1  1 = store, 0 = load; valid with data_request
- data_address  input  ADDRESS_WIDTH  load/store address
- data_write_data  input  DATA_WIDTH  store data
- data_ready  output  1  one-cycle pulse; load data valid / store done
- data_read_data  output  DATA_WIDTH  registered load word
- memory_address  output  ADDRESS_WIDTH  address to memory
- memory_write_data  output  DATA_WIDTH  write data to memory
- memory_write_enable  output  1  memory write strobe
- memory_read_data  input  DATA_WIDTH  memory read port, combinational from memory_address
- busy  output  1  high whenever state is not IDLE

## Operation
- All outputs are registered. On reset low at a clock edge:
  - state becomes IDLE.
  - every output becomes 0, including fetch_data, data_read_data, memory_address and memory_write_data.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Samples both requests.
  - If one or both are high, grants one, latches its address, direction and write data, and goes to ACCESS.
  - If neither is high, stays in IDLE.
- Priority when both requests are high in IDLE: data wins (see Configuration).
- ACCESS:
  - Drives the latched address and write data.
  - Loads a down-counter with WAIT_STATES on entry.
  - Decrements the counter each cycle.
  - In the cycle the counter equals 0:
    - for a read, captures memory_read_data into the granted requester's data register;
    - then goes to DONE.
- memory_write_enable is high only in the first ACCESS cycle of a store. It is never high for reads.
- DONE:
  - Pulses the granted side's ready for exactly one cycle.
  - The data register holds its value until the next read for that side.
  - Always returns to IDLE.
- Handshake: a requester holds its request and its address and data stable until it sees ready. It may deassert the request in the cycle ready is high.
  - A request still high in the IDLE cycle after DONE is treated as a new access.
- Request dropped mid-access: the access completes and ready still pulses. The requester ignores it.
- Input changes during ACCESS have no effect, because all access parameters are latched.
- The counter is sized to hold WAIT_STATES, minimum 1 bit. With WAIT_STATES = 0, ACCESS lasts exactly one cycle.

## Timing
- Cycle 0: request sampled high in IDLE.
- Cycles 1 to WAIT_STATES+1: ACCESS. memory_address is valid from cycle 1.
- Cycle WAIT_STATES+2: DONE. ready = 1 and the data output is valid.
- Latency from request to ready is WAIT_STATES+2 cycles.
- Minimum spacing between grants is WAIT_STATES+3 cycles.
- busy is high from cycle 1 through DONE inclusive.
- Reset low during ACCESS or DONE:
  - the next cycle is IDLE with all outputs 0;
  - no ready pulse is issued;
  - memory_write_enable is 0.
- memory_read_data must settle within WAIT_STATES+1 cycles of memory_address changing.

## Configuration
- ARBITER_ROUND_ROBIN_EN
  - Defined: a 1-bit last-granted register (reset value: fetch) alternates priority when both requests are high in IDLE. The side not granted last time wins. A single requester is always granted.
  - Undefined: fixed priority, with data over fetch. Fetch may starve while data_request stays high.

## Test plan
- Single load: WAIT_STATES=2; data_request=1, data_write=0, data_address=16'h0040; memory returns 32'hDEADBEEF.
  - Required: data_ready pulses exactly at cycle 4; data_read_data = 32'hDEADBEEF; memory_write_enable stays 0.
- Single store: data_address=16'h0010, data_write_data=32'h12345678.
  - Required: memory_write_enable high only in cycle 1, with memory_address=16'h0010 and memory_write_data=32'h12345678; data_ready at cycle 4.
- Contention: both requests high at cycle 0 and held.
  - Macro undefined: data granted first (data_ready at cycle 4), then fetch (fetch_ready at cycle 9).
  - Macro defined: data first after reset, because last-granted resets to fetch; then fetch; then a third simultaneous pair grants data again.
- Reset mid-access: assert reset=0 in cycle 2 of a store.
  - Required: cycle 3 is IDLE, all outputs 0, busy=0, no ready pulse, no further write strobe.
- WAIT_STATES=0 fetch at 16'h0002 returning 32'h0000A0B1.
  - Required: fetch_ready at cycle 2, fetch_data = 32'h0000A0B1; a held request gets its next grant in cycle 3.
